y86_inst_encoder: RTL

Byte-serial Y86-64 instruction encoder, the counterpart of the fetch-stage split/align/need_regids/need_valC decode logic. It accepts one decoded instruction (icode, ifun, rA, rB, valC) per handshake and emits its canonical little-endian byte image, one byte per cycle, with write addresses for instruction memory. It is used by the program loader and self-test path to build instruction memory images that the SEQ fetch stage decodes back to the same fields.

---
 rtl/y86_inst_encoder.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/y86_inst_encoder.sv
// Byte-serial Y86-64 instruction encoder: takes one decoded instruction per
// handshake and emits its little-endian byte image with instruction-memory addresses.
module y86_inst_encoder #(
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        icode,
  input  logic [3:0]        ifun,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic [63:0]       valC,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_byte,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HEAD  = 2'd1,
    S_REGS  = 2'd2,
    S_CONST = 2'd3
  } state_t;

  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] I_IADDQ  = 4'hC;

  state_t            state;
  logic [2:0]        beat;
  logic [2:0]        beat_nxt;
  logic [3:0]        icode_q;
  logic [3:0]        ra_q;
  logic [3:0]        rb_q;
  logic [63:0]       valc_q;
  logic [ADDR_W-1:0] addr_q;

  // Length classes mirror the fetch stage's need_regids / need_valC decode.
  function automatic logic is_illegal(input logic [3:0] c);
    return c inside {4'hD, 4'hE, 4'hF};
  endfunction

  function automatic logic has_regs(input logic [3:0] c);
    return c inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB, 4'hC};
  endfunction

  function automatic logic has_const(input logic [3:0] c);
    return c inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8, 4'hC};
  endfunction

  assign beat_nxt = beat + 3'd1;
  assign out_addr = addr_q;

  // NOTE: the instruction field registers are intentionally not reset; they
  // are only ever read after a fresh accept has loaded them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      beat      <= '0;
      addr_q    <= BASE_ADDR;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_byte  <= '0;
      err       <= 1'b0;
    end else begin
      // NOTE: every register here uses <= so all updates see pre-edge values.
      err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (addr_load) addr_q <= addr_in;
          if (in_valid) begin
            if (is_illegal(icode)) begin
              err <= 1'b1;
            end else begin
              icode_q   <= icode;
              ra_q      <= (icode == I_IRMOVQ || icode == I_IADDQ) ? 4'hF : rA;
              rb_q      <= (icode == I_PUSHQ  || icode == I_POPQ)  ? 4'hF : rB;
              valc_q    <= valC;
              beat      <= '0;
              state     <= S_HEAD;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_byte  <= {icode, ifun};
              out_last  <= !has_regs(icode) && !has_const(icode);
            end
          end
        end

        S_HEAD: begin
          if (out_ready) begin
            addr_q <= addr_q + ADDR_W'(1);
            if (has_regs(icode_q)) begin
              state    <= S_REGS;
              out_byte <= {ra_q, rb_q};
              out_last <= !has_const(icode_q);
            end else if (has_const(icode_q)) begin
              state    <= S_CONST;
              beat     <= '0;
              out_byte <= valc_q[7:0];
              out_last <= 1'b0;
            end else begin
              state     <= S_IDLE;
              in_ready  <= 1'b1;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_byte  <= '0;
            end
          end
        end

        S_REGS: begin
          if (out_ready) begin
            addr_q <= addr_q + ADDR_W'(1);
            if (has_const(icode_q)) begin
              state    <= S_CONST;
              beat     <= '0;
              out_byte <= valc_q[7:0];
              out_last <= 1'b0;
            end else begin
              state     <= S_IDLE;
              in_ready  <= 1'b1;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_byte  <= '0;
            end
          end
        end

        S_CONST: begin
          if (out_ready) begin
            addr_q <= addr_q + ADDR_W'(1);
            if (beat == 3'd7) begin
              state     <= S_IDLE;
              in_ready  <= 1'b1;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_byte  <= '0;
            end else begin
              beat     <= beat_nxt;
              out_byte <= valc_q[{beat_nxt, 3'b000} +: 8];
              out_last <= (beat_nxt == 3'd7);
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
